// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose:
//   Collects results from NUM_CH producer channels (ALU, LSB, ...) into small
//   per-channel in-order FIFOs and broadcasts one entry per cycle on the common
//   data bus (CDB). A round-robin pointer (last_grant) picks the winning
//   channel, starting one past the previous winner.
//
// Optional feature (compile-time macro CDB_ARB_BYPASS_EN):
//   When defined, an empty channel presenting an accepted entry may win
//   arbitration in the same cycle. Its entry goes straight to the CDB
//   registers and is not written into the FIFO, for one-edge latency.
//   When undefined, only FIFO heads compete, for two-edge latency.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-low reset
//   rdy       in   0 freezes every register and blocks all acceptance
//   flush     in   mispredict flush: drops every pending result
//   in_valid  in   [NUM_CH]         per-channel result valid
//   in_tag    in   [NUM_CH*TAG_W]   channel i at [i*TAG_W +: TAG_W]
//   in_data   in   [NUM_CH*DATA_W]  channel i at [i*DATA_W +: DATA_W]
//   in_ready  out  [NUM_CH]         channel i can accept this cycle
//   cdb_valid out  registered broadcast valid
//   cdb_tag   out  registered broadcast tag
//   cdb_data  out  registered broadcast data
//   cdb_src   out  registered index of the granted channel
//
// Handshake: an entry on channel i transfers at a rising edge exactly when
// in_valid[i] and in_ready[i] are both high. in_ready[i] is a pure function of
// rdy, flush and the channel's occupancy; it never depends on in_valid, and
// a full FIFO keeps in_ready low even in a cycle where its head is popped.
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        flush,
  input  logic [NUM_CH-1:0]           in_valid,
  input  logic [NUM_CH*TAG_W-1:0]     in_tag,
  input  logic [NUM_CH*DATA_W-1:0]    in_data,
  output logic [NUM_CH-1:0]           in_ready,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_data,
  output logic [$clog2(NUM_CH)-1:0]   cdb_src
);

  localparam int SRC_W = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Per-channel FIFO state.
  logic [CNT_W-1:0]  count_q  [NUM_CH];
  logic [CNT_W-1:0]  count_d  [NUM_CH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_CH];
  logic [TAG_W-1:0]  tag_mem_q  [NUM_CH][DEPTH];
  logic [DATA_W-1:0] data_mem_q [NUM_CH][DEPTH];

  // Arbitration and broadcast registers.
  logic [SRC_W-1:0]  last_grant_q, last_grant_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

  // Unpacked views of the packed input buses.
  logic [TAG_W-1:0]  in_tag_a  [NUM_CH];
  logic [DATA_W-1:0] in_data_a [NUM_CH];

  logic              accept_en;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] store;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] cand;
  logic              grant_valid;
  logic [SRC_W-1:0]  grant_idx;
  logic [TAG_W-1:0]  grant_tag;
  logic [DATA_W-1:0] grant_data;
  int                scan_idx;

  assign accept_en = rdy & ~flush;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      in_tag_a[i]  = in_tag[i*TAG_W +: TAG_W];
      in_data_a[i] = in_data[i*DATA_W +: DATA_W];
    end
  end

  // Acceptance and candidate selection.
  always_comb begin
    in_ready = '0;
    push     = '0;
    empty    = '0;
    cand     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready[i] = accept_en & (count_q[i] < CNT_W'(DEPTH));
      push[i]     = in_valid[i] & in_ready[i];
      empty[i]    = (count_q[i] == '0);
`ifdef CDB_ARB_BYPASS_EN
      cand[i]     = ~empty[i] | push[i];
`else
      cand[i]     = ~empty[i];
`endif
    end
  end

  // Round-robin: scan channels starting one past the last winner, first
  // candidate found wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      scan_idx = (int'(last_grant_q) + k) % NUM_CH;
      if (!grant_valid && cand[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = SRC_W'(scan_idx);
      end
    end
  end

  // Broadcast payload: FIFO head, or the live input when a bypass wins.
  always_comb begin
    grant_tag  = tag_mem_q[grant_idx][rd_ptr_q[grant_idx]];
    grant_data = data_mem_q[grant_idx][rd_ptr_q[grant_idx]];
`ifdef CDB_ARB_BYPASS_EN
    if (empty[grant_idx]) begin
      grant_tag  = in_tag_a[grant_idx];
      grant_data = in_data_a[grant_idx];
    end
`endif
  end

  // Pops only happen from non-empty FIFOs; a bypassed entry is never stored.
  always_comb begin
    pop   = '0;
    store = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop[i]   = accept_en & grant_valid & (grant_idx == SRC_W'(i)) & ~empty[i];
`ifdef CDB_ARB_BYPASS_EN
      store[i] = push[i] & ~(grant_valid & (grant_idx == SRC_W'(i)) & empty[i]);
`else
      store[i] = push[i];
`endif
    end
  end

  // Next state. rdy=0 leaves every register at its current value.
  always_comb begin
    last_grant_d = last_grant_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_tag_d    = cdb_tag_q;
    cdb_data_d   = cdb_data_q;
    cdb_src_d    = cdb_src_q;
    for (int i = 0; i < NUM_CH; i++) begin
      count_d[i]  = count_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
    end
    if (rdy) begin
      if (flush) begin
        // last_grant deliberately survives a flush.
        cdb_valid_d = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
          count_d[i]  = '0;
          wr_ptr_d[i] = '0;
          rd_ptr_d[i] = '0;
        end
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (store[i]) wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
          if (pop[i])   rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
          count_d[i] = count_q[i] + CNT_W'(store[i]) - CNT_W'(pop[i]);
        end
        cdb_valid_d = grant_valid;
        if (grant_valid) begin
          cdb_tag_d    = grant_tag;
          cdb_data_d   = grant_data;
          cdb_src_d    = grant_idx;
          last_grant_d = grant_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= SRC_W'(NUM_CH - 1);
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_data_q   <= '0;
      cdb_src_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i]  <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      last_grant_q <= last_grant_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_data_q   <= cdb_data_d;
      cdb_src_q    <= cdb_src_d;
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i]  <= count_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
    end
  end

  // Storage needs no reset: pointers and counts define what is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (store[i]) begin
        tag_mem_q[i][wr_ptr_q[i]]  <= in_tag_a[i];
        data_mem_q[i][wr_ptr_q[i]] <= in_data_a[i];
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int DEPTH  = 2;
  localparam int SRC_W  = $clog2(NUM_CH);
  localparam int ENT_W  = TAG_W + DATA_W;
  localparam int TW     = NUM_CH * TAG_W;
  localparam int DW     = NUM_CH * DATA_W;
`ifdef CDB_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rdy = 1'b1;
  logic              flush = 1'b0;
  logic [NUM_CH-1:0] in_valid = '0;
  logic [TW-1:0]     in_tag = '0;
  logic [DW-1:0]     in_data = '0;
  logic [NUM_CH-1:0] in_ready;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [SRC_W-1:0]  cdb_src;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_tag(in_tag), .in_data(in_data), .in_ready(in_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: per-channel queues ----------------
  logic [ENT_W-1:0]  exp_q [NUM_CH][$];
  int                m_last;
  logic              m_valid;
  logic [TAG_W-1:0]  m_tag;
  logic [DATA_W-1:0] m_data;
  logic [SRC_W-1:0]  m_src;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) exp_q[i].delete();
    m_last  = NUM_CH - 1;
    m_valid = 1'b0;
    m_tag   = '0;
    m_data  = '0;
    m_src   = '0;
  endtask

  function automatic logic [NUM_CH-1:0] model_ready();
    logic [NUM_CH-1:0] r;
    for (int i = 0; i < NUM_CH; i++)
      r[i] = rdy && !flush && (exp_q[i].size() < DEPTH);
    return r;
  endfunction

  function automatic logic [ENT_W-1:0] live_entry(input int c);
    return {in_tag[c*TAG_W +: TAG_W], in_data[c*DATA_W +: DATA_W]};
  endfunction

  task automatic model_step();
    logic [NUM_CH-1:0] acc;
    logic [ENT_W-1:0]  ent;
    int                g;
    int                c;
    if (!rdy) return;
    if (flush) begin
      for (int i = 0; i < NUM_CH; i++) exp_q[i].delete();
      m_valid = 1'b0;
      return;
    end
    acc = in_valid & model_ready();
    g = -1;
    for (int k = 1; k <= NUM_CH; k++) begin
      c = (m_last + k) % NUM_CH;
      if (g < 0 && (exp_q[c].size() > 0 || (BYP && acc[c]))) g = c;
    end
    if (g >= 0) begin
      if (exp_q[g].size() > 0) begin
        ent = exp_q[g].pop_front();
      end else begin
        ent    = live_entry(g);
        acc[g] = 1'b0;
      end
      {m_tag, m_data} = ent;
      m_valid = 1'b1;
      m_src   = SRC_W'(g);
      m_last  = g;
    end else begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < NUM_CH; i++)
      if (acc[i]) exp_q[i].push_back(live_entry(i));
  endtask

  // One clock: check in_ready mid-cycle, advance model, check registered outputs.
  task automatic run_cycle(output logic [NUM_CH-1:0] rs);
    @(negedge clk);
    rs = in_ready;
    chk("in_ready", in_ready, model_ready());
    model_step();
    @(posedge clk);
    #1;
    chk("cdb_valid", cdb_valid, m_valid);
    chk("cdb_tag", cdb_tag, m_tag);
    chk("cdb_data", cdb_data, m_data);
    chk("cdb_src", cdb_src, m_src);
  endtask

  task automatic drive(input logic [NUM_CH-1:0] v, input logic [TW-1:0] t, input logic [DW-1:0] d);
    in_valid = v;
    in_tag   = t;
    in_data  = d;
  endtask

  task automatic drive_rand(input logic [NUM_CH-1:0] v);
    drive(v, TW'($urandom), {$urandom, $urandom});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  valid;
    logic [3:0]  tag0, tag1;
    logic [31:0] data0, data1;
    logic [1:0]  exp_ready;
    logic        exp_valid;
    logic [3:0]  exp_tag;
    logic [31:0] exp_data;
    logic        exp_src;
  } vec_t;

  localparam int NV = 9;
  vec_t vec [NV];

  function automatic vec_t mk(input logic [1:0] v, input logic [3:0] t0, input logic [3:0] t1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic ev, input logic [3:0] et, input logic [31:0] ed,
                              input logic es);
    vec_t r;
    r.valid = v; r.tag0 = t0; r.tag1 = t1; r.data0 = d0; r.data1 = d1;
    r.exp_ready = 2'b11; r.exp_valid = ev; r.exp_tag = et; r.exp_data = ed; r.exp_src = es;
    return r;
  endfunction

  logic [NUM_CH-1:0] rs;
  logic              exp_alt;

  initial begin
    // Two results in one cycle, then a single-channel burst of three.
`ifdef CDB_ARB_BYPASS_EN
    vec[0] = mk(2'b11, 4'd3, 4'd5, 32'h11, 32'h22, 1'b1, 4'd3,  32'h11, 1'b0);
    vec[1] = mk(2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  1'b1, 4'd5,  32'h22, 1'b1);
    vec[2] = mk(2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  1'b0, 4'd5,  32'h22, 1'b1);
    vec[3] = mk(2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  1'b0, 4'd5,  32'h22, 1'b1);
    vec[4] = mk(2'b10, 4'd0, 4'd9, 32'h0,  32'hA9, 1'b1, 4'd9,  32'hA9, 1'b1);
    vec[5] = mk(2'b10, 4'd0, 4'd10, 32'h0, 32'hAA, 1'b1, 4'd10, 32'hAA, 1'b1);
    vec[6] = mk(2'b10, 4'd0, 4'd11, 32'h0, 32'hAB, 1'b1, 4'd11, 32'hAB, 1'b1);
    vec[7] = mk(2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  1'b0, 4'd11, 32'hAB, 1'b1);
    vec[8] = mk(2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  1'b0, 4'd11, 32'hAB, 1'b1);
`else
    vec[0] = mk(2'b11, 4'd3, 4'd5, 32'h11, 32'h22, 1'b0, 4'd0,  32'h0,  1'b0);
    vec[1] = mk(2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  1'b1, 4'd3,  32'h11, 1'b0);
    vec[2] = mk(2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  1'b1, 4'd5,  32'h22, 1'b1);
    vec[3] = mk(2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  1'b0, 4'd5,  32'h22, 1'b1);
    vec[4] = mk(2'b10, 4'd0, 4'd9, 32'h0,  32'hA9, 1'b0, 4'd5,  32'h22, 1'b1);
    vec[5] = mk(2'b10, 4'd0, 4'd10, 32'h0, 32'hAA, 1'b1, 4'd9,  32'hA9, 1'b1);
    vec[6] = mk(2'b10, 4'd0, 4'd11, 32'h0, 32'hAB, 1'b1, 4'd10, 32'hAA, 1'b1);
    vec[7] = mk(2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  1'b1, 4'd11, 32'hAB, 1'b1);
    vec[8] = mk(2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  1'b0, 4'd11, 32'hAB, 1'b1);
`endif

    // ---- reset state ----
    model_reset();
    #2;
    chk("rst_valid", cdb_valid, 1'b0);
    chk("rst_tag", cdb_tag, 0);
    chk("rst_data", cdb_data, 0);
    chk("rst_src", cdb_src, 0);
    chk("rst_ready", in_ready, 2'b11);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ---- table ----
    for (int r = 0; r < NV; r++) begin
      drive(vec[r].valid, {vec[r].tag1, vec[r].tag0}, {vec[r].data1, vec[r].data0});
      run_cycle(rs);
      chk("vec_ready", rs, vec[r].exp_ready);
      chk("vec_valid", cdb_valid, vec[r].exp_valid);
      chk("vec_tag", cdb_tag, vec[r].exp_tag);
      chk("vec_data", cdb_data, vec[r].exp_data);
      chk("vec_src", cdb_src, vec[r].exp_src);
    end

    // ---- both channels saturated: grants alternate starting at channel 0 ----
    exp_alt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_rand(2'b11);
      run_cycle(rs);
      if (BYP || i > 0) begin
        chk("sat_valid", cdb_valid, 1'b1);
        chk("sat_src", cdb_src, exp_alt);
        exp_alt = ~exp_alt;
      end
    end
    drive(2'b00, '0, '0);
    for (int i = 0; i < 6; i++) run_cycle(rs);

    // ---- flush with entries pending; inputs during flush are dropped ----
    drive_rand(2'b01);
    run_cycle(rs);
    drive_rand(2'b11);
    run_cycle(rs);
    drive_rand(2'b11);
    flush = 1'b1;
    run_cycle(rs);
    chk("flush_ready", rs, 2'b00);
    chk("flush_valid", cdb_valid, 1'b0);
    flush = 1'b0;
    drive(2'b00, '0, '0);
    for (int i = 0; i < 4; i++) begin
      run_cycle(rs);
      chk("post_flush_valid", cdb_valid, 1'b0);
    end

    // ---- rdy=0 freeze with entries pending ----
    drive_rand(2'b11);
    run_cycle(rs);
    drive_rand(2'b11);
    run_cycle(rs);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand(2'b11);
      run_cycle(rs);
      chk("freeze_ready", rs, 2'b00);
    end
    rdy = 1'b1;
    drive(2'b00, '0, '0);
    for (int i = 0; i < 6; i++) run_cycle(rs);

    // ---- asynchronous reset mid-burst ----
    drive_rand(2'b11);
    run_cycle(rs);
    drive_rand(2'b11);
    run_cycle(rs);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", cdb_valid, 1'b0);
    chk("arst_tag", cdb_tag, 0);
    chk("arst_data", cdb_data, 0);
    chk("arst_src", cdb_src, 0);
    model_reset();
    drive(2'b00, '0, '0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      run_cycle(rs);
      chk("post_rst_valid", cdb_valid, 1'b0);
    end

    // ---- single tag 7 on empty channel 0: latency check ----
    drive(2'b01, TW'(7), DW'(32'h77));
    run_cycle(rs);
    drive(2'b00, '0, '0);
`ifdef CDB_ARB_BYPASS_EN
    chk("lat_valid", cdb_valid, 1'b1);
    chk("lat_tag", cdb_tag, 4'd7);
    run_cycle(rs);
    chk("lat_after", cdb_valid, 1'b0);
`else
    chk("lat_early", cdb_valid, 1'b0);
    run_cycle(rs);
    chk("lat_valid", cdb_valid, 1'b1);
    chk("lat_tag", cdb_tag, 4'd7);
`endif
    run_cycle(rs);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 400; i++) begin
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 19) == 0);
      drive_rand(NUM_CH'($urandom));
      run_cycle(rs);
    end
    rdy   = 1'b1;
    flush = 1'b0;
    drive(2'b00, '0, '0);
    for (int i = 0; i < 8; i++) run_cycle(rs);
    for (int i = 0; i < NUM_CH; i++) chk("drained", exp_q[i].size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of producer channels (ALU, LSB, ...), range 2..8.
REQ-002 SHALL have parameter DATA_W, default 32: broadcast data width.
REQ-003 SHALL have parameter TAG_W, default 4: ROB tag width.
REQ-004 SHALL have parameter DEPTH, default 2: per-channel FIFO entries, power of two, 2..16.
REQ-005 SHALL have port clk  input  1  the one clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port rdy  input  1  0 = freeze all state.
REQ-008 SHALL have port flush  input  1  mispredict flush, discards all pending results.
REQ-009 SHALL have port in_valid  input  NUM_CH  per-channel result valid.
REQ-010 SHALL have port in_tag  input  NUM_CH*TAG_W  per-channel tag; channel i at [i*TAG_W +: TAG_W].
REQ-011 SHALL have port in_data  input  NUM_CH*DATA_W  per-channel data, same packing.
REQ-012 SHALL have port in_ready  output  NUM_CH  channel i can accept this cycle.
REQ-013 SHALL have port cdb_valid  output  1  broadcast valid, registered.
REQ-014 SHALL have port cdb_tag  output  TAG_W  broadcast tag, registered.
REQ-015 SHALL have port cdb_data  output  DATA_W  broadcast data, registered.
REQ-016 SHALL have port cdb_src  output  $clog2(NUM_CH)  index of granted channel, registered.

Function
REQ-017 SHALL accept a channel entry when in_valid[i] & in_ready[i] & rdy & !flush at a rising edge.
REQ-018 SHALL drive in_ready[i] = rdy & !flush & (count[i] < DEPTH), combinationally; a full FIFO SHALL deassert in_ready even if it pops that cycle.
REQ-019 SHALL keep each channel FIFO in order, with wrap-around read/write pointers and a count of width $clog2(DEPTH)+1.
REQ-020 SHALL each cycle grant exactly one non-empty channel, round-robin starting at (last_grant+1) mod NUM_CH; last_grant SHALL reset to NUM_CH-1, so channel 0 wins first.
REQ-021 SHALL register the granted head entry into cdb_valid/tag/data/src and pop it in the same edge; with no candidate, cdb_valid = 0 and tag/data/src hold their values.
REQ-022 SHALL give each cdb_valid pulse for exactly one cycle per entry; no entry broadcast twice, none lost except by flush.
REQ-023 SHALL with simultaneous push and pop on one channel keep count unchanged.
REQ-024 SHALL on flush (rdy=1) clear all counts and pointers and cdb_valid next edge; last_grant is kept; in_valid in the flush cycle is dropped.
REQ-025 SHALL when rdy=0 hold every register, accept nothing (in_ready=0) and keep cdb_valid at its current value.
REQ-026 SHALL without bypass have latency 2 edges from acceptance to cdb_valid (FIFO write, then grant).

Reset
REQ-027 SHALL on rst=0, asynchronously: counts, pointers, cdb_valid, cdb_tag, cdb_data, cdb_src = 0; last_grant = NUM_CH-1.
REQ-028 SHALL discard any in-flight entries when reset is asserted mid-operation; the first broadcast after release SHALL come only from entries accepted after release.

Configuration
REQ-029 SHALL when CDB_ARB_BYPASS_EN is defined treat an empty channel with in_valid & in_ready as a grant candidate in the same cycle, broadcasting in_tag/in_data directly without a FIFO write (latency 1 edge); when granted this way the entry SHALL NOT be stored.
REQ-030 SHALL when CDB_ARB_BYPASS_EN is undefined have only FIFO heads as candidates (REQ-026); arbitration order is identical in both builds.

Verification
REQ-031 SHALL cover: NUM_CH=2, ch0 tag 3 data 0x11 and ch1 tag 5 data 0x22 in the same cycle after reset -> cdb (3,0x11,src0), then next cycle (5,0x22,src1).
REQ-032 SHALL cover: DEPTH=2, ch1 valid 3 consecutive cycles, no other load -> in_ready[1] drops exactly when count=2; all accepted tags appear in order, none duplicated.
REQ-033 SHALL cover: both channels saturated 8 cycles -> cdb_src alternates 0,1,0,1...
REQ-034 SHALL cover: 2 entries pending, flush pulsed 1 cycle -> cdb_valid=0 next cycle, nothing broadcast afterwards until new input.
REQ-035 SHALL cover: rdy=0 for 3 cycles with entries pending -> outputs and in_ready=0 frozen; after rdy=1 broadcast resumes with the same order.
REQ-036 SHALL cover: rst asserted mid-burst with no clock edge -> all outputs 0 immediately; with CDB_ARB_BYPASS_EN, single input tag 7 on empty ch0 -> cdb_valid one edge later.
